// File: rtl/db_ram_responder_if.sv
// Word data-bus link between the CPU/MMU initiator (master) and a memory responder (slave).
// db_accessType encoding: 0 NONE, 1 R (read), 2 W (write), 3 X (execute fetch, served as a read).
interface db_ram_responder_if;
  logic [31:0] db_addr;
  logic [31:0] db_dataOut;
  logic [1:0]  db_accessType;
  logic [31:0] db_dataIn;
  logic        db_ready;

  modport master (
    output db_addr, db_dataOut, db_accessType,
    input  db_dataIn, db_ready
  );

  modport slave (
    input  db_addr, db_dataOut, db_accessType,
    output db_dataIn, db_ready
  );
endinterface

// File: rtl/db_ram_responder.sv
// Main-RAM data-bus responder: db_ready LATENCY cycles after a request; no backpressure, the
// initiator holds each request until db_ready. Optional sticky out-of-range fault: DB_RAM_FAULT_EN.
module db_ram_responder #(
  parameter              TAG        = "DB_RAM",
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic              clk,
  input  logic              res,
  db_ram_responder_if.slave bus,
  output logic              fault,
  output logic [31:0]       fault_addr
);
  localparam logic [1:0]  ACC_NONE = 2'd0;
  localparam logic [1:0]  ACC_W    = 2'd2;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam int unsigned WORDS    = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e                  state, state_nxt;
  logic [3:0]              cnt;
  logic [31:0]             lat_addr;
  logic [1:0]              lat_type;
  logic [31:0]             rd_lat;
  logic [31:0]             mem [WORDS];

  logic                    req;
  logic                    ready;
  logic                    is_write;
  logic                    is_read;
  logic                    in_range;
  logic [31:0]             acc_addr;
  logic [1:0]              acc_type;
  logic [29:0]             word_off;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [31:0]             mem_word;

  // TAG is only printed in debug builds; referencing it here keeps it elaborated in every build.
  if ($bits(TAG) == 0) begin : g_tag_unused
  end

  assign req = (bus.db_accessType != ACC_NONE);

  // With no wait states the access is served straight off the bus.
  assign acc_addr = (LATENCY == 0) ? bus.db_addr : lat_addr;
  assign acc_type = (LATENCY == 0) ? bus.db_accessType : lat_type;

  assign is_write = (acc_type == ACC_W);
  assign is_read  = acc_type[0];

  assign word_off = acc_addr[31:2] - BASE[31:2];
  assign in_range = ((word_off >> ADDR_WIDTH) == '0);
  assign word_idx = word_off[ADDR_WIDTH-1:0];
  assign mem_word = in_range ? mem[word_idx] : '0;

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && (LATENCY != 0)) state_nxt = WAIT;
      WAIT:    if (!req || (cnt == 4'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A request dropped to NONE mid-wait is an abort, so it never completes.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = (LATENCY == 0) && req && !res;
      WAIT:    ready = req && (cnt == 4'd0) && !res;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_type <= ACC_NONE;
    end else if ((state == IDLE) && req) begin
      cnt      <= CNT_INIT;
      lat_addr <= bus.db_addr;
      lat_type <= bus.db_accessType;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ready && is_write && in_range) begin
      mem[word_idx] <= bus.db_dataOut;
    end
  end

  // Writes leave the latch alone so a read-modify-write sees the read word throughout.
  always_ff @(posedge clk) begin
    if (res) begin
      rd_lat <= '0;
    end else if (ready && is_read) begin
      rd_lat <= mem_word;
    end
  end

  assign bus.db_dataIn = (ready && is_read) ? mem_word : rd_lat;
  assign bus.db_ready  = ready;

`ifdef DB_RAM_FAULT_EN
  always_ff @(posedge clk) begin
    if (res) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (ready && !in_range && !fault) begin
      fault      <= 1'b1;
      fault_addr <= acc_addr;
`ifdef DEBUG_DISPLAY
      $display("\033[31m%s: out-of-range access at 0x%08h\033[0m", TAG, acc_addr);
`endif
    end
  end
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^acc_addr[1:0];
  assign fault           = 1'b0;
  assign fault_addr      = '0;
`endif

endmodule

// File: tb/tb_db_ram_responder.sv
// Directed bench for db_ram_responder: three instances (LATENCY 1, 3, 0) checked every cycle
// against a transaction-level model, plus literal expectations from the test plan.
module tb_db_ram_responder;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] EX   = 2'd3;
  localparam int         ND   = 3;
`ifdef DB_RAM_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res_v  [ND];
  logic [31:0] a_addr [ND];
  logic [31:0] a_wdat [ND];
  logic [1:0]  a_type [ND];
  logic        rdy    [ND];
  logic [31:0] din    [ND];
  logic        flt    [ND];
  logic [31:0] flt_a  [ND];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  db_ram_responder_if bus0 ();
  db_ram_responder_if bus1 ();
  db_ram_responder_if bus2 ();

  assign bus0.db_addr = a_addr[0];  assign bus0.db_dataOut = a_wdat[0];  assign bus0.db_accessType = a_type[0];
  assign bus1.db_addr = a_addr[1];  assign bus1.db_dataOut = a_wdat[1];  assign bus1.db_accessType = a_type[1];
  assign bus2.db_addr = a_addr[2];  assign bus2.db_dataOut = a_wdat[2];  assign bus2.db_accessType = a_type[2];
  assign rdy[0] = bus0.db_ready;    assign din[0] = bus0.db_dataIn;
  assign rdy[1] = bus1.db_ready;    assign din[1] = bus1.db_dataIn;
  assign rdy[2] = bus2.db_ready;    assign din[2] = bus2.db_dataIn;

  db_ram_responder #(.TAG("RAM0"), .ADDR_WIDTH(12), .BASE(32'h0000_0000), .LATENCY(1)) u0 (
    .clk(clk), .res(res_v[0]), .bus(bus0.slave), .fault(flt[0]), .fault_addr(flt_a[0]));
  db_ram_responder #(.TAG("RAM1"), .ADDR_WIDTH(4), .BASE(32'h0000_1000), .LATENCY(3)) u1 (
    .clk(clk), .res(res_v[1]), .bus(bus1.slave), .fault(flt[1]), .fault_addr(flt_a[1]));
  db_ram_responder #(.TAG("RAM2"), .ADDR_WIDTH(12), .BASE(32'h0000_0000), .LATENCY(0)) u2 (
    .clk(clk), .res(res_v[2]), .bus(bus2.slave), .fault(flt[2]), .fault_addr(flt_a[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  function automatic longint base_of(input int d);
    return (d == 1) ? 64'h1000 : 64'h0;
  endfunction

  function automatic longint bytes_of(input int d);
    return (d == 1) ? 64'd64 : 64'd16384;
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] a);
    longint aa;
    aa = {32'b0, a};
    return (aa >= base_of(d)) && (aa < base_of(d) + bytes_of(d));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a request held since cycle s completes in cycle s+LATENCY; memory is a word map.
  logic [31:0] mm [bit [31:0]];
  int          start   [ND];
  logic [31:0] last_rd [ND];
  logic        m_flt   [ND];
  logic [31:0] m_flt_a [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      start[d]   = -1;
      last_rd[d] = '0;
      m_flt[d]   = 1'b0;
      m_flt_a[d] = '0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < ND; d++) begin
        bit          er;
        bit          known;
        bit          is_rd;
        bit [31:0]   key;
        logic [31:0] ed;
        er    = 1'b0;
        known = 1'b1;
        is_rd = (a_type[d] == RD) || (a_type[d] == EX);
        key   = {2'(d), a_addr[d][31:2]};
        if (res_v[d]) begin
          start[d] = -1;
        end else if (a_type[d] != NONE) begin
          if (start[d] < 0) start[d] = cyc;
          er = ((cyc - start[d]) == lat_of(d));
        end else begin
          start[d] = -1;
        end
        ed = last_rd[d];
        if (er && is_rd) begin
          if (!in_rng(d, a_addr[d])) ed = '0;
          else if (mm.exists(key)) ed = mm[key];
          else known = 1'b0;
        end
        check($sformatf("dut%0d ready", d), {31'b0, rdy[d]}, {31'b0, er});
        if (known) check($sformatf("dut%0d dataIn", d), din[d], ed);
        check($sformatf("dut%0d fault", d), {31'b0, flt[d]}, {31'b0, m_flt[d]});
        check($sformatf("dut%0d fault_addr", d), flt_a[d], m_flt_a[d]);
        if (res_v[d]) begin
          last_rd[d] = '0;
          m_flt[d]   = 1'b0;
          m_flt_a[d] = '0;
        end else if (er) begin
          if ((a_type[d] == WR) && in_rng(d, a_addr[d])) mm[key] = a_wdat[d];
          if (is_rd && known) last_rd[d] = ed;
          if (FEN && !in_rng(d, a_addr[d]) && !m_flt[d]) begin
            m_flt[d]   = 1'b1;
            m_flt_a[d] = a_addr[d];
          end
          start[d] = -1;
        end
      end
    end
  end

  // Presents one request (called #1 after a rising edge) and holds it until db_ready.
  task automatic access(input int d, input logic [1:0] t, input logic [31:0] a, input logic [31:0] w,
                        output logic [31:0] rd, output int lat);
    a_type[d] = t;
    a_addr[d] = a;
    a_wdat[d] = w;
    lat = 0;
    rd  = '0;
    forever begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        rd = din[d];
        break;
      end
      lat++;
      if (lat > 30) begin
        total++;
        bad++;
        $display("FAIL dut%0d timeout waiting for db_ready at addr %h", d, a);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic acc_chk(input int d, input logic [1:0] t, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] exp_rd, input int exp_lat, input string nm);
    logic [31:0] rd;
    int          lat;
    access(d, t, a, w, rd, lat);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " data"}, rd, exp_rd);
  endtask

  task automatic idle(input int d);
    a_type[d] = NONE;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      res_v[d]  = 1'b1;
      a_type[d] = NONE;
      a_addr[d] = '0;
      a_wdat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) res_v[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset dut%0d ready", d), {31'b0, rdy[d]}, 32'd0);
      check($sformatf("reset dut%0d dataIn", d), din[d], 32'd0);
      check($sformatf("reset dut%0d fault", d), {31'b0, flt[d]}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Write then read, one wait state.
    acc_chk(0, WR, 32'h10, 32'hA1B2C3D4, 32'h0, 1, "w10");
    idle(0);
    acc_chk(0, RD, 32'h10, 32'h0, 32'hA1B2C3D4, 1, "r10");
    idle(0);

    // Read-modify-write with no idle gap; the read word stays visible during the write.
    acc_chk(0, WR, 32'h20, 32'h11223344, 32'hA1B2C3D4, 1, "w20 preload");
    idle(0);
    acc_chk(0, RD, 32'h20, 32'h0, 32'h11223344, 1, "r20");
    acc_chk(0, WR, 32'h20, 32'h11AA3344, 32'h11223344, 1, "w20 rmw");
    acc_chk(0, RD, 32'h20, 32'h0, 32'h11AA3344, 1, "r20 after rmw");
    idle(0);

    // LATENCY=3 abort, then a fresh write completing three cycles later.
    a_type[1] = RD;
    a_addr[1] = 32'h1000;
    @(negedge clk);
    check("abort T0 ready", {31'b0, rdy[1]}, 32'd0);
    @(posedge clk);
    #1;
    a_type[1] = NONE;
    @(negedge clk);
    check("abort T1 ready", {31'b0, rdy[1]}, 32'd0);
    @(posedge clk);
    #1;
    acc_chk(1, WR, 32'h1004, 32'h0BADF00D, 32'h0, 3, "w1004 after abort");
    idle(1);
    acc_chk(1, RD, 32'h1004, 32'h0, 32'h0BADF00D, 3, "r1004");

    // Range boundaries of a 16-word window at 0x1000.
    acc_chk(1, WR, 32'h1000, 32'h13579BDF, 32'h0BADF00D, 3, "w1000");
    acc_chk(1, WR, 32'h103C, 32'hCAFE0001, 32'h0BADF00D, 3, "w103c top");
    acc_chk(1, WR, 32'h1040, 32'hDEAD0000, 32'h0BADF00D, 3, "w1040 dropped");
    acc_chk(1, RD, 32'h103C, 32'h0, 32'hCAFE0001, 3, "r103c top");
    acc_chk(1, RD, 32'h1000, 32'h0, 32'h13579BDF, 3, "r1000 no alias");
    acc_chk(1, RD, 32'h1040, 32'h0, 32'h0, 3, "r1040 above");
    acc_chk(1, RD, 32'h0FFC, 32'h0, 32'h0, 3, "r0ffc below");
    idle(1);

    // LATENCY=0: one access per cycle, execute fetches served as reads.
    acc_chk(2, WR, 32'h0, 32'h01020304, 32'h0, 0, "w0 lat0");
    acc_chk(2, WR, 32'h4, 32'h05060708, 32'h0, 0, "w4 lat0");
    acc_chk(2, WR, 32'h8, 32'h090A0B0C, 32'h0, 0, "w8 lat0");
    acc_chk(2, EX, 32'h0, 32'h0, 32'h01020304, 0, "x0 lat0");
    acc_chk(2, EX, 32'h4, 32'h0, 32'h05060708, 0, "x4 lat0");
    acc_chk(2, EX, 32'h8, 32'h0, 32'h090A0B0C, 0, "x8 lat0");
    idle(2);

    // Out-of-range accesses and the sticky fault capture.
    check("fault before oor", {31'b0, flt[0]}, 32'd0);
    acc_chk(0, RD, 32'h4000, 32'h0, 32'h0, 1, "r4000 oor");
    idle(0);
    check("fault after oor", {31'b0, flt[0]}, FEN ? 32'd1 : 32'd0);
    check("fault_addr after oor", flt_a[0], FEN ? 32'h4000 : 32'h0);
    acc_chk(0, RD, 32'h8000, 32'h0, 32'h0, 1, "r8000 oor");
    idle(0);
    check("fault_addr sticky", flt_a[0], FEN ? 32'h4000 : 32'h0);

    // Reset in the middle of a write wait: no commit, read latch cleared.
    acc_chk(1, WR, 32'h1030, 32'h5555AAAA, 32'h0, 3, "w1030");
    acc_chk(1, RD, 32'h1000, 32'h0, 32'h13579BDF, 3, "r1000 before reset");
    a_type[1] = WR;
    a_addr[1] = 32'h1030;
    a_wdat[1] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    res_v[1]  = 1'b1;
    a_type[1] = NONE;
    @(posedge clk);
    #1;
    res_v[1] = 1'b0;
    @(negedge clk);
    check("dataIn after reset", din[1], 32'h0);
    check("ready after reset", {31'b0, rdy[1]}, 32'd0);
    @(posedge clk);
    #1;
    acc_chk(1, RD, 32'h1030, 32'h0, 32'h5555AAAA, 3, "r1030 after reset");
    idle(1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/db_ram_responder.md
# db_ram_responder

Word-wide memory responder for the data bus driven by the CPU/MMU complex. It accepts read, write and execute requests, models a fixed number of wait states, and answers with a `db_ready` completion strobe. It keeps the last read word stable on `db_dataIn` so the initiator can run sub-word read-modify-write cycles without an idle gap. It sits behind the physical-address side of the MMU as the main RAM target.

## Interface
- `TAG`, `"DB_RAM"` — prefix for debug display messages.
- `ADDR_WIDTH`, `12` — log2 of the number of 32-bit words stored (default 4096 words, 16 KiB).
- `BASE`, `32'h0000_0000` — byte address of word 0; must be aligned to 4·2^ADDR_WIDTH.
- `LATENCY`, `1` — wait cycles from request to `db_ready`, range 0..15.
- `clk`  in  1 — clock; all state changes on the rising edge.
- `res`  in  1 — reset, synchronous, active-high.
- `db_addr`  in  32 — physical byte address; bits [1:0] ignored.
- `db_dataOut`  in  32 — write data from the initiator.
- `db_accessType`  in  `MEM_ACCESS` — `MEM_ACCESS_NONE`, `_R`, `_W`, `_X`.
- `db_dataIn`  out  32 — read data to the initiator.
- `db_ready`  out  1 — completion strobe, high for exactly one cycle per request.
- `fault`  out  1 — sticky out-of-range flag (see Configuration).
- `fault_addr`  out  32 — address of the first out-of-range access.

## Operation
- States: `IDLE`, `WAIT`.
- A request is present when `db_accessType != MEM_ACCESS_NONE`. It is sampled only in `IDLE`.
- `MEM_ACCESS_X` behaves exactly like `MEM_ACCESS_R`.
- LATENCY=0:
  - `db_ready` is combinational in the sampling cycle: `IDLE` and request present.
  - The state remains `IDLE`.
- LATENCY≥1:
  - In the sampling cycle, latch the address and type, load the counter with LATENCY−1, and go to `WAIT`.
  - In `WAIT`, assert `db_ready` when the counter is 0; otherwise decrement the counter.
  - Return to `IDLE` on the edge that ends the ready cycle.
- Abort: if `db_accessType` reads NONE during `WAIT`, go to `IDLE`. No write is committed and `db_ready` is not asserted.
- In the ready cycle, `db_accessType` may already show the initiator's next request. The responder ignores it in that cycle and samples it in the following cycle.
- Word index is `(addr − BASE) >> 2`. An access is in range when `addr[31:2]` lies within `BASE[31:2] .. BASE[31:2] + 2^ADDR_WIDTH − 1`.
- Write: the array word is updated on the edge that ends the ready cycle, using `db_dataOut` from that cycle. Out-of-range writes are dropped.
- Read: the array is read asynchronously at the latched index.
  - `db_dataIn` = array word during the ready cycle.
  - At all other times, `db_dataIn` = the read-data latch, updated on the edge ending each read ready cycle.
  - Out-of-range reads return 0.
- Writes do not change the read-data latch. The word from a preceding read therefore stays on `db_dataIn` through a following write.
- Byte order: byte offset 0 maps to bits [31:24], offset 3 to bits [7:0]. Sub-word merging is done upstream.
- Reset values:
  - state `IDLE`, counter 0
  - `db_ready` 0 (LATENCY=0: 0 until a request is present)
  - `db_dataIn` 0 (read-data latch cleared)
  - `fault` 0, `fault_addr` 0
  - Array contents are not reset.
- Reset during `WAIT` cancels the access, with no write commit and no `db_ready`.

## Timing
- The request is held from cycle T. `db_ready` is high in cycle T+LATENCY.
- Back-to-back: the next request can be sampled in cycle T+LATENCY+1. Throughput is one access per LATENCY+1 cycles (LATENCY=0: one per cycle).
- Read data is valid in the ready cycle and held until the next read completes.
- Write data is sampled only in the ready cycle. The initiator must hold `db_dataOut` stable until then.

## Configuration
- `DB_RAM_FAULT_EN`
  - Defined: the first out-of-range access completed (`db_ready` still pulses) sets `fault`=1 and captures `fault_addr`=db_addr. Both stay fixed until reset. Under `DEBUG_DISPLAY`, a red message tagged `TAG` is printed.
  - Undefined: `fault` and `fault_addr` are tied to 0 and no fault logic is built. Out-of-range behaviour is otherwise identical.

## Test plan
- LATENCY=1, W 0x0000_0010 ← 0xA1B2C3D4, then R 0x0000_0010 → `db_ready` one cycle after each request, read returns 0xA1B2C3D4.
- R 0x20 (word 0x11223344), then immediately in the next cycle W 0x20 ← 0x11AA3344 with no idle gap → `db_dataIn` holds 0x11223344 through the write, and a subsequent read returns 0x11AA3344.
- LATENCY=3, hold R at T, then drive NONE at T+1 → no `db_ready`, state returns to `IDLE`. A fresh W at T+2 completes at T+5.
- LATENCY=0, X requests on consecutive cycles to 0x0, 0x4, 0x8 → `db_ready` high in every cycle and data matches the preloaded words.
- `DB_RAM_FAULT_EN`, ADDR_WIDTH=12: R 0x0000_4000 → returns 0, `db_ready` pulses, `fault`=1 and `fault_addr`=0x0000_4000. A later out-of-range access to 0x8000 leaves `fault_addr` unchanged.
- Assert `res` for one cycle during `WAIT` of W 0x30 ← 0xFFFFFFFF → no `db_ready`, R 0x30 returns the prior value, and `db_dataIn` reads 0 immediately after reset.
